// File: rtl/tetris_pkg.sv
// Shared board geometry, field widths, op encodings and the plotter FSM
// state type. Also consumed by the game controller.
package tetris_pkg;

  localparam int BOARD_COLS     = 10;
  localparam int BOARD_ROWS     = 20;
  localparam int CELL_PX        = 5;
  localparam int BOARD_ORIGIN_X = 55;
  localparam int BOARD_ORIGIN_Y = 10;

  localparam int COLOUR_W = 6;
  localparam int X_W      = 8;
  localparam int Y_W      = 7;
  localparam int COL_W    = 4;
  localparam int ROW_W    = 5;

  localparam logic OP_CELL  = 1'b0;
  localparam logic OP_CLEAR = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_DRAW
  } plot_state_t;

  typedef struct packed {
    logic                op;
    logic [COL_W-1:0]    col;
    logic [ROW_W-1:0]    row;
    logic [COLOUR_W-1:0] colour;
  } plot_req_t;

  localparam int REQ_W = $bits(plot_req_t);

  // Screen coordinate of a cell edge, kept at 9 bits so the caller decides
  // how to truncate to the screen axis width.
  function automatic logic [8:0] cell_base(input logic [8:0] origin,
                                           input logic [8:0] idx,
                                           input logic [8:0] cell_px);
    return origin + idx * cell_px;
  endfunction

endpackage

// File: rtl/cell_plotter_if.sv
// Request bus from the game controller into the cell plotter.
interface cell_plotter_if;
  import tetris_pkg::*;

  logic                req_valid;
  logic                req_ready;
  logic                req_op;
  logic [COL_W-1:0]    req_col;
  logic [ROW_W-1:0]    req_row;
  logic [COLOUR_W-1:0] req_colour;

  modport master (
    output req_valid, req_op, req_col, req_row, req_colour,
    input  req_ready
  );

  modport slave (
    input  req_valid, req_op, req_col, req_row, req_colour,
    output req_ready
  );

endinterface

// File: rtl/plot_fifo.sv
// Small synchronous request FIFO with a combinational head read, so the
// consumer can inspect the oldest entry in the same cycle it pops it.
module plot_fifo #(
  parameter  int WIDTH = 16,
  parameter  int DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty,
  output logic [CNT_W-1:0] count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem[rd_ptr];

  // Storage array; contents are don't-care until written, so no reset.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= wdata;
    end
  end

  // Pointers and occupancy; pointers wrap naturally since DEPTH is a power of two.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/cell_plotter.sv
// Expands queued board-cell draw and board-clear requests into a stream of
// single-pixel writes for the VGA adapter, one pixel per clock.
module cell_plotter
  import tetris_pkg::*;
#(
  parameter int                  CELL_SIZE    = CELL_PX,
  parameter int                  ORIGIN_X     = BOARD_ORIGIN_X,
  parameter int                  ORIGIN_Y     = BOARD_ORIGIN_Y,
  parameter int                  BOARD_W      = BOARD_COLS,
  parameter int                  BOARD_H      = BOARD_ROWS,
  parameter logic [COLOUR_W-1:0] CLEAR_COLOUR = 6'b000000,
  parameter int                  FIFO_DEPTH   = 4
) (
  input  logic                clk,
  input  logic                reset_n,
  cell_plotter_if.slave       req,
  output logic [X_W-1:0]      X,
  output logic [Y_W-1:0]      Y,
  output logic [COLOUR_W-1:0] colour,
  output logic                writeEn,
  output logic                busy,
  output logic                req_dropped
);

  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

  if ((ORIGIN_X + BOARD_W * CELL_SIZE > 160) ||
      (ORIGIN_Y + BOARD_H * CELL_SIZE > 120)) begin : g_geom_check
    $error("cell_plotter: board does not fit on the 160x120 screen");
  end

  plot_state_t         state;
  plot_state_t         state_next;

  logic                fifo_full;
  logic                fifo_empty;
  logic [CNT_W-1:0]    fifo_count;
  logic [REQ_W-1:0]    head_bits;
  plot_req_t           head;
  logic                push;
  logic                pop;
  logic                drop;

  logic [8:0]          load_x9;
  logic [8:0]          load_y9;
  logic [X_W-1:0]      load_w;
  logic [Y_W-1:0]      load_h;
  logic [COLOUR_W-1:0] load_colour;
  logic                head_bad;

  logic [X_W-1:0]      base_x;
  logic [Y_W-1:0]      base_y;
  logic [X_W-1:0]      ext_w;
  logic [Y_W-1:0]      ext_h;
  logic [X_W-1:0]      dx;
  logic [Y_W-1:0]      dy;
  logic                last_x;
  logic                last_y;

  assign req.req_ready = !fifo_full;
  assign push          = req.req_valid && !fifo_full;
  assign head          = plot_req_t'(head_bits);
  assign busy          = !fifo_empty || (state != ST_IDLE);
  assign last_x        = (dx == ext_w - X_W'(1));
  assign last_y        = (dy == ext_h - Y_W'(1));

  plot_fifo #(
    .WIDTH (REQ_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .push    (push),
    .wdata   ({req.req_op, req.req_col, req.req_row, req.req_colour}),
    .pop     (pop),
    .rdata   (head_bits),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (fifo_count)
  );

  // Decode the FIFO head into a rectangle: origin, extent, colour, validity.
  always_comb begin
    load_x9     = 9'(ORIGIN_X);
    load_y9     = 9'(ORIGIN_Y);
    load_w      = X_W'(CELL_SIZE);
    load_h      = Y_W'(CELL_SIZE);
    load_colour = head.colour;
    head_bad    = 1'b0;
    if (head.op == OP_CLEAR) begin
      load_w      = X_W'(BOARD_W * CELL_SIZE);
      load_h      = Y_W'(BOARD_H * CELL_SIZE);
      load_colour = CLEAR_COLOUR;
    end else begin
      load_x9  = cell_base(9'(ORIGIN_X), 9'(head.col), 9'(CELL_SIZE));
      load_y9  = cell_base(9'(ORIGIN_Y), 9'(head.row), 9'(CELL_SIZE));
      head_bad = (32'(head.col) >= BOARD_W) || (32'(head.row) >= BOARD_H);
    end
  end

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next state plus FIFO pop / drop control; a same-cycle push counts as work pending.
  always_comb begin
    state_next = state;
    pop        = 1'b0;
    drop       = 1'b0;
    case (state)
      ST_IDLE: begin
        if (!fifo_empty) begin
          state_next = ST_LOAD;
        end
      end
      ST_LOAD: begin
        pop = 1'b1;
        if (head_bad) begin
          drop       = 1'b1;
          state_next = ((fifo_count > CNT_W'(1)) || push) ? ST_LOAD : ST_IDLE;
        end else begin
          state_next = ST_DRAW;
        end
      end
      ST_DRAW: begin
        if (last_x && last_y) begin
          state_next = (!fifo_empty || push) ? ST_LOAD : ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // Rectangle walker: LOAD registers the first pixel, DRAW steps dx inside dy.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      base_x      <= '0;
      base_y      <= '0;
      ext_w       <= '0;
      ext_h       <= '0;
      dx          <= '0;
      dy          <= '0;
      X           <= '0;
      Y           <= '0;
      colour      <= '0;
      writeEn     <= 1'b0;
      req_dropped <= 1'b0;
    end else begin
      req_dropped <= drop;
      case (state)
        ST_LOAD: begin
          if (head_bad) begin
            writeEn <= 1'b0;
          end else begin
            base_x  <= X_W'(load_x9);
            base_y  <= Y_W'(load_y9);
            ext_w   <= load_w;
            ext_h   <= load_h;
            dx      <= '0;
            dy      <= '0;
            X       <= X_W'(load_x9);
            Y       <= Y_W'(load_y9);
            colour  <= load_colour;
            writeEn <= 1'b1;
          end
        end
        ST_DRAW: begin
          if (last_x && last_y) begin
            writeEn <= 1'b0;
          end else if (last_x) begin
            dx      <= '0;
            dy      <= dy + Y_W'(1);
            X       <= base_x;
            Y       <= base_y + dy + Y_W'(1);
            writeEn <= 1'b1;
          end else begin
            dx      <= dx + X_W'(1);
            X       <= base_x + dx + X_W'(1);
            writeEn <= 1'b1;
          end
        end
        default: begin
          writeEn <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cell_plotter.sv
// Directed self-checking bench for cell_plotter: single cells, board
// corner, full clear, back-to-back queueing, dropped requests and reset.
module tb_cell_plotter;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [7:0] X;
  logic [6:0] Y;
  logic [5:0] colour;
  logic       writeEn;
  logic       busy;
  logic       req_dropped;

  cell_plotter_if bus();

  cell_plotter dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .req         (bus),
    .X           (X),
    .Y           (Y),
    .colour      (colour),
    .writeEn     (writeEn),
    .busy        (busy),
    .req_dropped (req_dropped)
  );

  // 100 MHz bench clock.
  always #5 clk = ~clk;

  // Edge counter used to time-stamp observed pixel writes.
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int   wx[$];
  int   wy[$];
  int   wc[$];
  int   wcyc[$];
  int   drop_count    = 0;
  int   stall_count   = 0;
  int   busy_fall_cyc = -1;
  logic prev_busy     = 1'b0;

  // Pixel-write monitor, sampled on the falling edge.
  always @(negedge clk) begin
    if (writeEn === 1'b1) begin
      wx.push_back(int'(X));
      wy.push_back(int'(Y));
      wc.push_back(int'(colour));
      wcyc.push_back(cyc);
    end
    if (req_dropped === 1'b1) drop_count++;
    if (bus.req_valid && !bus.req_ready) stall_count++;
    if (prev_busy && !busy) busy_fall_cyc = cyc;
    prev_busy = busy;
  end

  int check_total = 0;
  int check_bad   = 0;
  int log_start   = 0;
  int drop_base   = 0;
  int stall_base  = 0;

  task automatic checkOutput(input string tag, input int observed, input int expected);
    check_total++;
    if (observed !== expected) begin
      check_bad++;
      $display("[TB] FAIL %s: got %0d expected %0d", tag, observed, expected);
    end
  endtask

  function automatic int pix(input int x, input int y, input int c);
    return (x << 16) | (y << 8) | c;
  endfunction

  function automatic int pixel_at(input int k);
    if (k < 0 || k >= wx.size()) return -1;
    return pix(wx[k], wy[k], wc[k]);
  endfunction

  function automatic int cyc_at(input int k);
    if (k < 0 || k >= wcyc.size()) return -1;
    return wcyc[k];
  endfunction

  function automatic int n_writes();
    return wx.size() - log_start;
  endfunction

  task automatic markLog();
    log_start  = wx.size();
    drop_base  = drop_count;
    stall_base = stall_count;
  endtask

  // Drives one request and returns the edge count at which it was accepted.
  task automatic applyStimulus(input logic op, input int col, input int row,
                               input int c, output int acc);
    int n;
    bus.req_op     = op;
    bus.req_col    = 4'(col);
    bus.req_row    = 5'(row);
    bus.req_colour = 6'(c);
    bus.req_valid  = 1'b1;
    n = 0;
    while (!bus.req_ready && n < 400) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (n >= 400) checkOutput("accept_timeout", 0, 1);
    @(posedge clk);
    #1;
    acc = cyc;
  endtask

  task automatic releaseBus();
    bus.req_valid = 1'b0;
  endtask

  task automatic waitIdle(input int max_cycles);
    int n;
    n = 0;
    while (busy && n < max_cycles) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (busy) checkOutput("idle_timeout", 0, 1);
    repeat (3) @(posedge clk);
    #1;
  endtask

  // Checks 25 consecutive logged writes against a cell at (col,row).
  task automatic checkCell(input string tag, input int idx0, input int col,
                           input int row, input int c);
    for (int i = 0; i < 25; i++) begin
      checkOutput($sformatf("%s_px%0d", tag, i), pixel_at(idx0 + i),
                  pix(55 + col * 5 + i % 5, 10 + row * 5 + i / 5, c));
    end
  endtask

  int acc;
  int bad;
  int s;

  initial begin
    bus.req_valid  = 1'b0;
    bus.req_op     = 1'b0;
    bus.req_col    = '0;
    bus.req_row    = '0;
    bus.req_colour = '0;
    reset_n        = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("rst_writeEn", int'(writeEn), 0);
    checkOutput("rst_busy", int'(busy), 0);
    checkOutput("rst_dropped", int'(req_dropped), 0);
    checkOutput("rst_ready", int'(bus.req_ready), 1);
    checkOutput("rst_xyc", pix(int'(X), int'(Y), int'(colour)), 0);
    reset_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    $display("[TB] single cell (0,0)");
    markLog();
    applyStimulus(1'b0, 0, 0, 6'h30, acc);
    releaseBus();
    waitIdle(200);
    s = log_start;
    checkOutput("cell0_count", n_writes(), 25);
    checkCell("cell0", s, 0, 0, 6'h30);
    checkOutput("cell0_latency", cyc_at(s) - acc, 2);
    checkOutput("cell0_span", cyc_at(s + 24) - cyc_at(s), 24);
    checkOutput("cell0_busy_fall", busy_fall_cyc, cyc_at(s + 24) + 1);

    $display("[TB] corner cell (9,19)");
    markLog();
    applyStimulus(1'b0, 9, 19, 6'h0F, acc);
    releaseBus();
    waitIdle(200);
    checkOutput("corner_count", n_writes(), 25);
    checkCell("corner", log_start, 9, 19, 6'h0F);
    checkOutput("corner_first", pixel_at(log_start), pix(100, 105, 6'h0F));
    checkOutput("corner_last", pixel_at(log_start + 24), pix(104, 109, 6'h0F));

    $display("[TB] board clear");
    markLog();
    applyStimulus(1'b1, 3, 4, 6'h3F, acc);
    releaseBus();
    waitIdle(6000);
    s = log_start;
    checkOutput("clear_count", n_writes(), 5000);
    checkOutput("clear_first", pixel_at(s), pix(55, 10, 0));
    checkOutput("clear_last", pixel_at(s + 4999), pix(104, 109, 0));
    bad = 0;
    for (int i = 0; i < 5000; i++) begin
      if (pixel_at(s + i) != pix(55 + i % 50, 10 + i / 50, 0)) bad++;
    end
    checkOutput("clear_raster_bad", bad, 0);

    $display("[TB] six back-to-back requests");
    markLog();
    for (int r = 0; r < 6; r++) begin
      applyStimulus(1'b0, r + 1, r, r + 1, acc);
    end
    releaseBus();
    waitIdle(400);
    s = log_start;
    checkOutput("b2b_count", n_writes(), 150);
    checkOutput("b2b_stalled", int'((stall_count - stall_base) > 0), 1);
    for (int r = 0; r < 6; r++) begin
      checkCell($sformatf("b2b%0d", r), s + 25 * r, r + 1, r, r + 1);
    end
    for (int r = 0; r < 5; r++) begin
      checkOutput($sformatf("b2b_bubble%0d", r),
                  cyc_at(s + 25 * r + 25) - cyc_at(s + 25 * r + 24), 2);
    end

    $display("[TB] out-of-range cell then valid cell");
    markLog();
    applyStimulus(1'b0, 10, 3, 6'h3F, acc);
    applyStimulus(1'b0, 2, 2, 6'h0C, acc);
    releaseBus();
    waitIdle(200);
    checkOutput("drop_pulses", drop_count - drop_base, 1);
    checkOutput("drop_count", n_writes(), 25);
    checkCell("after_drop", log_start, 2, 2, 6'h0C);

    $display("[TB] reset during clear");
    markLog();
    applyStimulus(1'b1, 0, 0, 0, acc);
    applyStimulus(1'b0, 1, 1, 6'h11, acc);
    applyStimulus(1'b0, 2, 2, 6'h22, acc);
    releaseBus();
    for (int n = 0; n < 400 && n_writes() < 100; n++) begin
      @(posedge clk);
      #1;
    end
    checkOutput("rst_mid_reached", int'(n_writes() >= 100), 1);
    reset_n = 1'b0;
    #1;
    checkOutput("rst_mid_writeEn", int'(writeEn), 0);
    checkOutput("rst_mid_busy", int'(busy), 0);
    checkOutput("rst_mid_ready", int'(bus.req_ready), 1);
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
    markLog();
    repeat (50) @(posedge clk);
    #1;
    checkOutput("rst_post_writes", n_writes(), 0);
    checkOutput("rst_post_busy", int'(busy), 0);

    markLog();
    applyStimulus(1'b0, 4, 7, 6'h2A, acc);
    releaseBus();
    waitIdle(200);
    checkOutput("recover_count", n_writes(), 25);
    checkCell("recover", log_start, 4, 7, 6'h2A);

    $display("test done: total=%0d bad=%0d", check_total, check_bad);
    $finish;
  end

endmodule

// File: doc/cell_plotter.md
# cell_plotter

Pixel-drawing stage between the game controller and the 160x120 VGA adapter. Accepts cell-level draw requests (board column/row plus colour) and whole-board clear requests through a valid/ready handshake, buffers them in a small FIFO, and expands each into a stream of single-pixel writes (`X`, `Y`, `colour`, `writeEn`) at one pixel per clock. The controller then issues board-cell operations and no longer computes pixel addresses.

## Interface
Parameters:
- `CELL_SIZE`, 5, edge length of one board cell in pixels
- `ORIGIN_X`, 55, screen x of board's top-left pixel
- `ORIGIN_Y`, 10, screen y of board's top-left pixel
- `BOARD_W`, 10, board width in cells
- `BOARD_H`, 20, board height in cells
- `CLEAR_COLOUR`, 6'b000000, colour used by clear requests
- `FIFO_DEPTH`, 4, request FIFO entries (power of two)

Ports:
- `clk`  in  1  system clock (CLOCK_50)
- `reset_n`  in  1  reset, asynchronous assert, active-low
- `req_valid`  in  1  request present
- `req_ready`  out  1  FIFO can accept; equals !full
- `req_op`  in  1  0 = draw cell, 1 = clear board
- `req_col`  in  4  cell column (ignored for clear)
- `req_row`  in  5  cell row (ignored for clear)
- `req_colour`  in  6  cell colour RRGGBB (ignored for clear)
- `X`  out  8  pixel x to VGA adapter
- `Y`  out  7  pixel y to VGA adapter
- `colour`  out  6  pixel colour
- `writeEn`  out  1  pixel write strobe
- `busy`  out  1  FIFO non-empty or FSM not IDLE
- `req_dropped`  out  1  one-cycle pulse: out-of-range cell request discarded

## Operation
- Push on rising edge with `req_valid && req_ready`. Requests are drawn strictly in FIFO order.
- FSM states:
  - IDLE: FIFO non-empty -> LOAD.
  - LOAD: pop head; latch op/colour; compute base and extent.
    - Cell with `req_col >= BOARD_W` or `req_row >= BOARD_H`: pulse `req_dropped`, go to IDLE if FIFO empty after pop, else stay in LOAD.
    - Otherwise -> DRAW.
  - DRAW: emit one pixel per cycle. `dx` is the inner counter, `dy` the outer. On the last pixel -> LOAD if FIFO non-empty, else IDLE.
- Cell draw:
  - Base = (`ORIGIN_X + col*CELL_SIZE`, `ORIGIN_Y + row*CELL_SIZE`).
  - Extent CELL_SIZE x CELL_SIZE, i.e. 25 pixels at defaults.
- Clear:
  - Base = (`ORIGIN_X`, `ORIGIN_Y`).
  - Extent (BOARD_W*CELL_SIZE) x (BOARD_H*CELL_SIZE), i.e. 50x100 = 5000 pixels, colour `CLEAR_COLOUR`.
- Arithmetic:
  - Base computed at 9-bit width, truncated to 8 bits for X and 7 bits for Y.
  - Elaboration-time check: `ORIGIN_X + BOARD_W*CELL_SIZE <= 160` and `ORIGIN_Y + BOARD_H*CELL_SIZE <= 120`. Under this check no pixel leaves the screen.
- `X`, `Y`, `colour`, `writeEn` are registered. When `writeEn` is 0, `X`/`Y`/`colour` hold their last values.
- Simultaneous push and pop are legal whenever not full. When full, `req_ready` is 0; the slot freed by a pop is visible one cycle later.

## Timing
- Reset (async, `reset_n` low):
  - FSM -> IDLE; FIFO emptied.
  - `X`, `Y`, `colour`, `writeEn`, `busy`, `req_dropped` = 0; `req_ready` = 1.
  - Reset mid-draw aborts immediately, with no further pixels.
- Latency: request accepted at edge k with FSM idle and FIFO empty.
  - LOAD at edge k+1.
  - First pixel registered at edge k+2; `writeEn` high in the cycle following k+2.
- Throughput:
  - 1 pixel/clock within a request.
  - Exactly one bubble cycle (LOAD) between consecutive requests.
  - Dropped requests cost one LOAD cycle each.
- `busy` goes high the cycle after a push. It goes low the cycle after the last pixel write when no requests remain.

## Structure
- Shared package `tetris_pkg`:
  - board dimensions, cell size, origin
  - `COLOUR_W` = 6, `X_W` = 8, `Y_W` = 7
  - op encoding constants `OP_CELL` / `OP_CLEAR`
  - FSM state enum
  - Also consumed by `control`.
- Sub-module `plot_fifo`: synchronous FIFO, width 16 (op + col + row + colour), depth FIFO_DEPTH, with `full`/`empty` flags and asynchronous active-low reset.
- Top level: FSM, `dx`/`dy` counters, base/extent registers, output registers.

## Test plan
- Single cell (col 0, row 0, colour 6'h30) from idle:
  - 25 writes, X 55..59 inner, Y 10..14 outer, colour 6'h30.
  - First `writeEn` 2 edges after acceptance.
  - `busy` low after the last write.
- Corner cell (col 9, row 19):
  - pixels X 100..104, Y 105..109.
  - no write outside.
- Clear request:
  - exactly 5000 writes, colour 0.
  - first (55,10), last (104,109).
- 6 back-to-back requests with `req_valid` held:
  - `req_ready` drops after 4 queued.
  - all 6 drawn in order, one bubble between each.
  - no request lost or duplicated.
- Out-of-range cell (col 10, row 3):
  - one `req_dropped` pulse.
  - zero writes.
  - next queued request drawn normally.
- `reset_n` pulsed low mid-clear (after 100 pixels) with 2 requests queued:
  - `writeEn` 0 immediately.
  - FIFO empty, `busy` 0.
  - no writes after release until a new request arrives.
